// File: rtl/voice_scheduler_pkg.sv
// Shared types and constants for the voice scheduler: default widths, voice count,
// buffer state encoding and the round-robin pointer update.
package voice_scheduler_pkg;

  localparam int VS_NOTE_WIDTH     = 6;
  localparam int VS_DURATION_WIDTH = 6;
  localparam int VS_NUM_VOICES     = 3;

  typedef enum logic {
    VS_EMPTY   = 1'b0,
    VS_PENDING = 1'b1
  } vs_state_e;

  // Pointer moves to the voice after the one just granted, wrapping at 3.
  function automatic logic [1:0] next_rr(input logic [2:0] grant);
    logic [1:0] r;
    case (grant)
      3'b010:  r = 2'd2;
      3'b100:  r = 2'd0;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Song-reader side of the scheduler: one {note, duration} offer per valid/ready handshake.
interface voice_scheduler_if
  import voice_scheduler_pkg::*;
#(
  parameter int NOTE_WIDTH     = VS_NOTE_WIDTH,
  parameter int DURATION_WIDTH = VS_DURATION_WIDTH
);

  logic                      in_valid;
  logic                      in_ready;
  logic [NOTE_WIDTH-1:0]     in_note;
  logic [DURATION_WIDTH-1:0] in_duration;

  modport master (
    output in_valid,
    output in_note,
    output in_duration,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_note,
    input  in_duration,
    output in_ready
  );

endinterface

// File: rtl/voice_scheduler_rr_pick3.sv
// Combinational round-robin picker over three voices: first free voice starting at rr.
module rr_pick3 (
  input  logic [2:0] free,
  input  logic [1:0] rr,
  output logic [2:0] grant,
  output logic       any_free
);

  always_comb begin
    grant    = 3'b000;
    any_free = |free;
    case (rr)
      2'd1: begin
        if (free[1])      grant = 3'b010;
        else if (free[2]) grant = 3'b100;
        else if (free[0]) grant = 3'b001;
      end
      2'd2: begin
        if (free[2])      grant = 3'b100;
        else if (free[0]) grant = 3'b001;
        else if (free[1]) grant = 3'b010;
      end
      default: begin
        if (free[0])      grant = 3'b001;
        else if (free[1]) grant = 3'b010;
        else if (free[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: buffers one note from the song reader and issues it round-robin
// to a free note player, tracking player busy state from their done pulses.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NOTE_WIDTH     = VS_NOTE_WIDTH,
  parameter int DURATION_WIDTH = VS_DURATION_WIDTH,
  parameter int NUM_VOICES     = VS_NUM_VOICES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  voice_scheduler_if.slave          song,
  input  logic [2:0]                voice_done,
  output logic [2:0]                load_note,
  output logic [NOTE_WIDTH-1:0]     note_one,
  output logic [NOTE_WIDTH-1:0]     note_two,
  output logic [NOTE_WIDTH-1:0]     note_three,
  output logic [DURATION_WIDTH-1:0] duration_one,
  output logic [DURATION_WIDTH-1:0] duration_two,
  output logic [DURATION_WIDTH-1:0] duration_three,
  output logic [2:0]                voice_busy,
  output logic                      all_idle
);

  vs_state_e                 state_q, state_d;
  logic [1:0]                rr_q, rr_d;
  logic [2:0]                busy_q, busy_d;
  logic [2:0]                load_q, load_d;
  logic [NOTE_WIDTH-1:0]     buf_note_q, buf_note_d;
  logic [DURATION_WIDTH-1:0] buf_dur_q, buf_dur_d;
  logic [NOTE_WIDTH-1:0]     note_q [NUM_VOICES];
  logic [NOTE_WIDTH-1:0]     note_d [NUM_VOICES];
  logic [DURATION_WIDTH-1:0] dur_q  [NUM_VOICES];
  logic [DURATION_WIDTH-1:0] dur_d  [NUM_VOICES];

  logic [2:0] grant;
  logic       any_free;
  logic       accept;
  logic       issue;

  rr_pick3 u_pick (
    .free     (~busy_q),
    .rr       (rr_q),
    .grant    (grant),
    .any_free (any_free)
  );

  // Ready depends only on state and play so the song reader never sees a loop through in_valid.
  assign song.in_ready = (state_q == VS_EMPTY) && play;
  assign accept        = song.in_valid && song.in_ready;
  assign issue         = (state_q == VS_PENDING) && play && any_free;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    buf_note_d = buf_note_q;
    buf_dur_d  = buf_dur_q;
    load_d     = 3'b000;
    note_d     = note_q;
    dur_d      = dur_q;
    // Set from an issue overrides a same-edge clear; the picker never grants a busy voice anyway.
    busy_d     = (busy_q & ~voice_done) | (issue ? grant : 3'b000);

    case (state_q)
      VS_EMPTY: begin
        if (accept) begin
          buf_note_d = song.in_note;
          buf_dur_d  = song.in_duration;
          // Zero duration is a rest: taken from the reader but never issued.
          if (song.in_duration != '0) state_d = VS_PENDING;
        end
      end
      VS_PENDING: begin
        if (issue) begin
          load_d  = grant;
          rr_d    = next_rr(grant);
          state_d = VS_EMPTY;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (grant[i]) begin
              note_d[i] = buf_note_q;
              dur_d[i]  = buf_dur_q;
            end
          end
        end
      end
      default: state_d = VS_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= VS_EMPTY;
      rr_q       <= 2'd0;
      busy_q     <= 3'b000;
      load_q     <= 3'b000;
      buf_note_q <= '0;
      buf_dur_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        dur_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      buf_note_q <= buf_note_d;
      buf_dur_q  <= buf_dur_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
    end
  end

  assign load_note      = load_q;
  assign voice_busy     = busy_q;
  assign note_one       = note_q[0];
  assign note_two       = note_q[1];
  assign note_three     = note_q[2];
  assign duration_one   = dur_q[0];
  assign duration_two   = dur_q[1];
  assign duration_three = dur_q[2];
  assign all_idle       = (state_q == VS_EMPTY) && (busy_q == 3'b000);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: issue latency, round-robin order, rests,
// pause behaviour and mid-operation reset, each against hand-computed values.
module tb_voice_scheduler;

  logic       clk;
  logic       reset;
  logic       play;
  logic [2:0] voice_done;
  logic [2:0] load_note;
  logic [5:0] note_one, note_two, note_three;
  logic [5:0] duration_one, duration_two, duration_three;
  logic [2:0] voice_busy;
  logic       all_idle;

  int checks;
  int errors;

  voice_scheduler_if #(.NOTE_WIDTH(6), .DURATION_WIDTH(6)) sif ();

  voice_scheduler #(.NOTE_WIDTH(6), .DURATION_WIDTH(6), .NUM_VOICES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .play           (play),
    .song           (sif.slave),
    .voice_done     (voice_done),
    .load_note      (load_note),
    .note_one       (note_one),
    .note_two       (note_two),
    .note_three     (note_three),
    .duration_one   (duration_one),
    .duration_two   (duration_two),
    .duration_three (duration_three),
    .voice_busy     (voice_busy),
    .all_idle       (all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // Offers one note and returns just after the accepting edge.
  task automatic send(input logic [5:0] n, input logic [5:0] d);
    int cnt;
    cnt = 0;
    sif.in_valid    = 1'b1;
    sif.in_note     = n;
    sif.in_duration = d;
    while (!sif.in_ready && cnt < 20) begin
      step(1);
      cnt++;
    end
    checks++;
    if (sif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout note=%0d in_ready=%b required 1", n, sif.in_ready);
    end
    step(1);
    sif.in_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [2:0] d);
    voice_done = d;
    step(1);
    voice_done = 3'b000;
  endtask

  task automatic test_reset();
    play = 1'b0;
    do_reset();
    checks++;
    if (voice_busy !== 3'b000 || load_note !== 3'b000 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b load=%b idle=%b required 000 000 1", voice_busy, load_note, all_idle);
    end
    checks++;
    if ({note_one, note_two, note_three, duration_one, duration_two, duration_three} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data n=%0d,%0d,%0d d=%0d,%0d,%0d required all 0",
               note_one, note_two, note_three, duration_one, duration_two, duration_three);
    end
    checks++;
    if (sif.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_paused in_ready=%b required 0", sif.in_ready);
    end
    play = 1'b1;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_follows_play in_ready=%b required 1", sif.in_ready);
    end
  endtask

  task automatic test_single();
    send(6'd10, 6'd4);
    checks++;
    if (sif.in_ready !== 1'b0 || load_note !== 3'b000 || all_idle !== 1'b0) begin
      errors++;
      $display("FAIL single_pending ready=%b load=%b idle=%b required 0 000 0", sif.in_ready, load_note, all_idle);
    end
    step(1);
    checks++;
    if (load_note !== 3'b001 || note_one !== 6'd10 || duration_one !== 6'd4 || voice_busy !== 3'b001) begin
      errors++;
      $display("FAIL single_issue load=%b note=%0d dur=%0d busy=%b required 001 10 4 001",
               load_note, note_one, duration_one, voice_busy);
    end
    step(1);
    checks++;
    if (load_note !== 3'b000) begin
      errors++;
      $display("FAIL single_strobe_width load=%b required 000", load_note);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(6'd10, 6'd1);
    send(6'd11, 6'd2);
    send(6'd12, 6'd3);
    send(6'd13, 6'd4);
    step(2);
    checks++;
    if (voice_busy !== 3'b111 || sif.in_ready !== 1'b0 || load_note !== 3'b000) begin
      errors++;
      $display("FAIL b2b_stall busy=%b ready=%b load=%b required 111 0 000", voice_busy, sif.in_ready, load_note);
    end
    checks++;
    if (note_one !== 6'd10 || note_two !== 6'd11 || note_three !== 6'd12) begin
      errors++;
      $display("FAIL b2b_notes n=%0d,%0d,%0d required 10,11,12", note_one, note_two, note_three);
    end
    pulse_done(3'b010);
    checks++;
    if (voice_busy !== 3'b101 || load_note !== 3'b000) begin
      errors++;
      $display("FAIL b2b_clear busy=%b load=%b required 101 000", voice_busy, load_note);
    end
    step(1);
    checks++;
    if (load_note !== 3'b010 || note_two !== 6'd13 || duration_two !== 6'd4 || voice_busy !== 3'b111) begin
      errors++;
      $display("FAIL b2b_reissue load=%b note_two=%0d dur_two=%0d busy=%b required 010 13 4 111",
               load_note, note_two, duration_two, voice_busy);
    end
  endtask

  task automatic test_round_robin();
    pulse_done(3'b001);
    send(6'd20, 6'd5);
    step(1);
    checks++;
    if (load_note !== 3'b001 || note_one !== 6'd20) begin
      errors++;
      $display("FAIL rr_wrap load=%b note_one=%0d required 001 20", load_note, note_one);
    end
    pulse_done(3'b101);
    send(6'd21, 6'd7);
    step(1);
    checks++;
    if (load_note !== 3'b100 || note_three !== 6'd21 || duration_three !== 6'd7 || note_one !== 6'd20) begin
      errors++;
      $display("FAIL rr_order load=%b note_three=%0d dur_three=%0d note_one=%0d required 100 21 7 20",
               load_note, note_three, duration_three, note_one);
    end
  endtask

  task automatic test_rest();
    sif.in_valid    = 1'b1;
    sif.in_note     = 6'd20;
    sif.in_duration = 6'd0;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rest_ready in_ready=%b required 1", sif.in_ready);
    end
    step(1);
    sif.in_valid = 1'b0;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1 || load_note !== 3'b000) begin
      errors++;
      $display("FAIL rest_stays_empty ready=%b load=%b required 1 000", sif.in_ready, load_note);
    end
    step(1);
    checks++;
    if (load_note !== 3'b000 || duration_one !== 6'd5 || note_two !== 6'd13 || note_three !== 6'd21) begin
      errors++;
      $display("FAIL rest_no_issue load=%b dur_one=%0d n2=%0d n3=%0d required 000 5 13 21",
               load_note, duration_one, note_two, note_three);
    end
  endtask

  task automatic test_pause();
    send(6'd30, 6'd3);
    step(1);
    send(6'd31, 6'd9);
    play = 1'b0;
    voice_done = 3'b001;
    step(1);
    voice_done = 3'b000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (load_note !== 3'b000 || sif.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold cyc=%0d load=%b ready=%b required 000 0", i, load_note, sif.in_ready);
      end
      step(1);
    end
    checks++;
    if (voice_busy !== 3'b110 || note_one !== 6'd30 || duration_one !== 6'd3) begin
      errors++;
      $display("FAIL pause_done busy=%b note_one=%0d dur_one=%0d required 110 30 3",
               voice_busy, note_one, duration_one);
    end
    play = 1'b1;
    step(1);
    checks++;
    if (load_note !== 3'b001 || note_one !== 6'd31 || duration_one !== 6'd9 || voice_busy !== 3'b111) begin
      errors++;
      $display("FAIL pause_resume load=%b note_one=%0d dur_one=%0d busy=%b required 001 31 9 111",
               load_note, note_one, duration_one, voice_busy);
    end
  endtask

  task automatic test_reset_mid();
    send(6'd40, 6'd1);
    do_reset();
    checks++;
    if (voice_busy !== 3'b000 || load_note !== 3'b000 || sif.in_ready !== 1'b1 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ctrl busy=%b load=%b ready=%b idle=%b required 000 000 1 1",
               voice_busy, load_note, sif.in_ready, all_idle);
    end
    checks++;
    if ({note_one, note_two, note_three, duration_one, duration_two, duration_three} !== 36'd0) begin
      errors++;
      $display("FAIL midreset_data n=%0d,%0d,%0d d=%0d,%0d,%0d required all 0",
               note_one, note_two, note_three, duration_one, duration_two, duration_three);
    end
    step(2);
    checks++;
    if (load_note !== 3'b000 || voice_busy !== 3'b000) begin
      errors++;
      $display("FAIL midreset_dropped load=%b busy=%b required 000 000", load_note, voice_busy);
    end
    send(6'd50, 6'd2);
    step(1);
    checks++;
    if (load_note !== 3'b001 || note_one !== 6'd50 || duration_one !== 6'd2) begin
      errors++;
      $display("FAIL midreset_rr load=%b note_one=%0d dur_one=%0d required 001 50 2",
               load_note, note_one, duration_one);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    play            = 1'b0;
    voice_done      = 3'b000;
    sif.in_valid    = 1'b0;
    sif.in_note     = '0;
    sif.in_duration = '0;
    step(2);
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_rest();
    test_pause();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
